robo_limpa_tubos: RTL and testbench
===================================

ROBO_LIMPA_TUBOS -- requirements
Module: robo_limpa_tubos

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; ports are named clock and reset.
REQ-002 clock  in  1  system clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 head  in  1  wall or map edge directly ahead.
REQ-005 left  in  1  wall or map edge on the robot's left.
REQ-006 under  in  1  debris in the current cell.
REQ-007 barrier  in  1  removable barrier in the cell ahead (head=0 in that case).
REQ-008 front  out  1  one-cycle pulse: advance one cell.
REQ-009 turn  out  1  one-cycle pulse: rotate 90 degrees left (N->W, W->S, S->E, E->N).
REQ-010 remove  out  1  one-cycle pulse: clean debris under the robot or the barrier ahead; the robot does not move.

Function
REQ-011 SHALL keep a 1-bit phase register; reset clears it; it toggles every clock afterwards.
REQ-012 SHALL make a decision only on edges where phase=1 (2nd, 4th, ... edge after reset release), using the sensors sampled on that edge; sensors are stable for 2 clocks per move.
REQ-013 SHALL register outputs; exactly one of front/turn/remove is 1 for the cycle after a decision edge; all are 0 in every other cycle.
REQ-014 SHALL implement states SEARCH, FOLLOW, ADVANCE, ROT_A, ROT_B; reset state SEARCH.
REQ-015 SHALL keep a just_removed flag; set by a remove decision, cleared by any other decision.
REQ-016 Remove rule (all states except ROT_A/ROT_B): (under=1 or barrier=1) and just_removed=0 -> remove, state unchanged.
REQ-017 Path clear SHALL mean head=0 and (barrier=0 or just_removed=1).
REQ-018 SEARCH: left=1 -> apply FOLLOW rules this decision; else clear -> front; else turn, go ROT_A.
REQ-019 FOLLOW: left=0 -> turn, go ADVANCE; else clear -> front; else turn, go ROT_A.
REQ-020 ADVANCE: clear -> front, go FOLLOW; else turn, go ROT_A.
REQ-021 ROT_A: turn, go ROT_B; ROT_B: turn, go FOLLOW; sensors ignored (three left turns = one right turn).
REQ-022 Remove rule SHALL have priority over all movement rules; after one remove the next decision moves even if under/barrier stays 1.

Reset
REQ-023 Reset SHALL force phase=0, state=SEARCH, just_removed=0, front=turn=remove=0 on the next edge.
REQ-024 Reset asserted mid-rotation or mid-removal SHALL discard the pending action; no output pulse follows.

Configuration
REQ-025 With macro ROBO_REMOVE_EN defined, removal follows REQ-015/016/022.
REQ-026 Without ROBO_REMOVE_EN, remove is tied 0, under is ignored, barrier=1 is treated as head=1, and just_removed is not implemented.

Structure
REQ-027 Package robo_limpa_tubos_pkg SHALL hold the state enum (3 bits) and a 2-bit orientation type (N=00, S=01, E=10, W=11) shared with benches.
REQ-028 Single module; no sub-module.

Verification
REQ-029 Reset held 3 cycles, then all sensors 0 -> no pulse on the 1st edge, front on the 2nd, 4th, 6th edge.
REQ-030 SEARCH, head=1 left=0 -> turn on three consecutive decisions (ROT_A, ROT_B, FOLLOW); net N->E.
REQ-031 FOLLOW, left=0 head=0 -> turn then front (ADVANCE), even if left still 0 on the second decision.
REQ-032 FOLLOW, left=1 head=0 barrier=1 -> remove, then front on the next decision with barrier still 1.
REQ-033 under=1 in FOLLOW -> remove once; with ROBO_REMOVE_EN undefined -> no remove, front.
REQ-034 reset=1 during ROT_A -> outputs 0, state SEARCH; next decision with head=0 -> front.

Source files
------------

// File: rtl/robo_limpa_tubos_pkg.sv
// Shared types for the pipe-cleaning robot controller: FSM states, decided actions
// and the 2-bit heading encoding used by the controller and its benches.
package robo_limpa_tubos_pkg;

  typedef enum logic [2:0] {
    SEARCH  = 3'd0,
    FOLLOW  = 3'd1,
    ADVANCE = 3'd2,
    ROT_A   = 3'd3,
    ROT_B   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ACT_NONE   = 2'd0,
    ACT_FRONT  = 2'd1,
    ACT_TURN   = 2'd2,
    ACT_REMOVE = 2'd3
  } act_t;

  typedef enum logic [1:0] {
    ORI_N = 2'b00,
    ORI_S = 2'b01,
    ORI_E = 2'b10,
    ORI_W = 2'b11
  } orient_t;

  // Heading after one 90-degree left turn.
  function automatic orient_t rot_left(input orient_t o);
    case (o)
      ORI_N:   return ORI_W;
      ORI_W:   return ORI_S;
      ORI_S:   return ORI_E;
      default: return ORI_N;
    endcase
  endfunction

endpackage

// File: rtl/robo_limpa_tubos.sv
// Left-wall-following pipe-cleaning robot controller, deciding every second clock.
// Define ROBO_REMOVE_EN to enable debris/barrier removal; otherwise barriers act as walls.
module robo_limpa_tubos
  import robo_limpa_tubos_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic head,
  input  logic left,
  input  logic under,
  input  logic barrier,
  output logic front,
  output logic turn,
  output logic remove
);

  state_t state_q, state_d;
  act_t   act_d;
  logic   phase_q;
  logic   front_q, turn_q;
  logic   clear;
  logic   remove_req;

`ifdef ROBO_REMOVE_EN
  logic just_removed_q;
  logic remove_q;

  // A barrier just removed no longer blocks the cell ahead.
  assign clear      = ~head & (~barrier | just_removed_q);
  assign remove_req = (under | barrier) & ~just_removed_q;
  assign remove     = remove_q;
`else
  logic unused_under;

  assign unused_under = under;
  assign clear        = ~head & ~barrier;
  assign remove_req   = 1'b0;
  assign remove       = 1'b0;
`endif

  assign front = front_q;
  assign turn  = turn_q;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    act_d   = ACT_NONE;
    case (state_q)
      ROT_A: begin
        act_d   = ACT_TURN;
        state_d = ROT_B;
      end
      ROT_B: begin
        act_d   = ACT_TURN;
        state_d = FOLLOW;
      end
      default: begin
        if (remove_req) begin
          act_d = ACT_REMOVE;
        end else if (state_q == ADVANCE) begin
          act_d   = clear ? ACT_FRONT : ACT_TURN;
          state_d = clear ? FOLLOW : ROT_A;
        end else if (state_q == FOLLOW && !left) begin
          act_d   = ACT_TURN;
          state_d = ADVANCE;
        end else if (clear) begin
          act_d   = ACT_FRONT;
          state_d = (state_q == FOLLOW || left) ? FOLLOW : SEARCH;
        end else begin
          // Blocked: three left turns make the right turn.
          act_d   = ACT_TURN;
          state_d = ROT_A;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q        <= 1'b0;
      state_q        <= SEARCH;
      front_q        <= 1'b0;
      turn_q         <= 1'b0;
`ifdef ROBO_REMOVE_EN
      remove_q       <= 1'b0;
      just_removed_q <= 1'b0;
`endif
    end else begin
      phase_q <= ~phase_q;
      front_q <= 1'b0;
      turn_q  <= 1'b0;
`ifdef ROBO_REMOVE_EN
      remove_q <= 1'b0;
`endif
      if (phase_q) begin
        state_q <= state_d;
        front_q <= (act_d == ACT_FRONT);
        turn_q  <= (act_d == ACT_TURN);
`ifdef ROBO_REMOVE_EN
        remove_q       <= (act_d == ACT_REMOVE);
        just_removed_q <= (act_d == ACT_REMOVE);
`endif
      end
    end
  end

endmodule

// File: tb/tb_robo_limpa_tubos.sv
// Directed bench for robo_limpa_tubos; expectations follow ROBO_REMOVE_EN when defined.
module tb_robo_limpa_tubos;
  import robo_limpa_tubos_pkg::*;

  localparam logic [2:0] NONE = 3'b000;
  localparam logic [2:0] FRW  = 3'b100;
  localparam logic [2:0] TRN  = 3'b010;
  localparam logic [2:0] REM  = 3'b001;

  logic clock = 1'b0;
  logic reset, head, left, under, barrier;
  logic front, turn, remove;
  orient_t ori;
  int n_checks = 0;
  int n_fail   = 0;

  robo_limpa_tubos dut (
    .clock   (clock),
    .reset   (reset),
    .head    (head),
    .left    (left),
    .under   (under),
    .barrier (barrier),
    .front   (front),
    .turn    (turn),
    .remove  (remove)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [2:0] outs();
    return {front, turn, remove};
  endfunction

  // One move: a quiet edge followed by a decision edge.
  task automatic decide(input string tag, input logic [2:0] exp);
    tick();
    check({tag, "_quiet"}, 32'(outs()), 32'(NONE));
    tick();
    check(tag, 32'(outs()), 32'(exp));
    if (turn) ori = rot_left(ori);
  endtask

  task automatic sense(input logic h, input logic l, input logic u, input logic b);
    head = h; left = l; under = u; barrier = b;
  endtask

  initial begin
    reset = 1'b1;
    sense(0, 0, 0, 0);
    ori = ORI_N;
    repeat (3) tick();
    check("rst_outs", 32'(outs()), 32'(NONE));
    check("rst_state", 32'(dut.state_q), 32'(SEARCH));
    check("rst_phase", 32'(dut.phase_q), 32'd0);
    reset = 1'b0;

    // Open space from SEARCH: front on every second edge.
    decide("open1", FRW);
    decide("open2", FRW);
    decide("open3", FRW);
    check("open_state", 32'(dut.state_q), 32'(SEARCH));

    // Wall ahead, no left wall: right turn via three left turns.
    sense(1, 0, 0, 0);
    decide("rot1", TRN);
    check("rot1_state", 32'(dut.state_q), 32'(ROT_A));
    sense(0, 1, 1, 1);
    decide("rot2", TRN);
    decide("rot3", TRN);
    check("rot_state", 32'(dut.state_q), 32'(FOLLOW));
    check("rot_heading", 32'(ori), 32'(ORI_E));

    // Lost the left wall: turn into the gap, then advance regardless of left.
    sense(0, 0, 0, 0);
    decide("gap_turn", TRN);
    check("gap_state", 32'(dut.state_q), 32'(ADVANCE));
    decide("gap_front", FRW);
    check("gap_follow", 32'(dut.state_q), 32'(FOLLOW));

    // Barrier ahead while following.
    sense(0, 1, 0, 1);
`ifdef ROBO_REMOVE_EN
    decide("bar_remove", REM);
    check("bar_hold", 32'(dut.state_q), 32'(FOLLOW));
    decide("bar_front", FRW);
`else
    decide("bar_turn1", TRN);
    decide("bar_turn2", TRN);
    decide("bar_turn3", TRN);
`endif
    check("bar_state", 32'(dut.state_q), 32'(FOLLOW));

    // Debris under the robot while following.
    sense(0, 1, 1, 0);
`ifdef ROBO_REMOVE_EN
    decide("dbr_remove", REM);
`else
    decide("dbr_front0", FRW);
`endif
    decide("dbr_front", FRW);
    sense(0, 1, 0, 0);

    // ADVANCE blocked: go into the rotation sequence.
    sense(0, 0, 0, 0);
    decide("adv_turn", TRN);
    sense(1, 0, 0, 0);
    decide("adv_block", TRN);
    check("adv_rota", 32'(dut.state_q), 32'(ROT_A));
    decide("adv_rotb", TRN);
    decide("adv_fol", TRN);

    // Reset landing on what would be a decision edge during ROT_A.
    sense(1, 1, 0, 0);
    decide("mid_turn", TRN);
    check("mid_rota", 32'(dut.state_q), 32'(ROT_A));
    tick();
    check("mid_quiet", 32'(outs()), 32'(NONE));
    reset = 1'b1;
    tick();
    check("mid_rst_outs", 32'(outs()), 32'(NONE));
    check("mid_rst_state", 32'(dut.state_q), 32'(SEARCH));
    tick();
    check("mid_rst_outs2", 32'(outs()), 32'(NONE));
    reset = 1'b0;
    sense(0, 0, 0, 0);
    decide("post_rst", FRW);

`ifdef ROBO_REMOVE_EN
    // Reset right after a remove decision leaves no flag behind.
    sense(0, 0, 1, 0);
    decide("rm_pre", REM);
    reset = 1'b1;
    tick();
    check("rm_rst_outs", 32'(outs()), 32'(NONE));
    reset = 1'b0;
    decide("rm_again", REM);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
